// File: rtl/present_dec_key_sched.sv
// PRESENT-80 decryption key schedule: expands the master key forward to the final state,
// then walks it back with the inverse update, streaming round keys K32 down to K1.
module present_dec_key_sched (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [79:0] key_in,
   input  logic        load,
   output logic        busy,
   output logic [63:0] rk_out,
   output logic [4:0]  rk_idx,
   output logic        rk_valid,
   input  logic        rk_ready,
   output logic        done
);

   localparam logic [3:0] Sbox [16] = '{
      4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
      4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
   };
   localparam logic [3:0] SboxInv [16] = '{
      4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
      4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
   };

   typedef enum logic [1:0] {StIdle, StExpand, StEmit} state_e;

   state_e      state_q, state_d;
   logic [79:0] kr_q, kr_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        done_q, done_d;
   logic        hs;

   function automatic logic [79:0] fwd_step(input logic [79:0] x, input logic [4:0] i);
      logic [79:0] r;
      r          = {x[18:0], x[79:19]};
      r[79:76]   = Sbox[r[79:76]];
      r[19:15]   = r[19:15] ^ i;
      return r;
   endfunction

   function automatic logic [79:0] inv_step(input logic [79:0] y, input logic [4:0] i);
      logic [79:0] t;
      t          = y;
      t[79:76]   = SboxInv[t[79:76]];
      t[19:15]   = t[19:15] ^ i;
      return {t[60:0], t[79:61]};
   endfunction

   assign hs = (state_q == StEmit) && rk_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:   if (load) state_d = StExpand;
         StExpand: if (cnt_q == 5'd31) state_d = StEmit;
         StEmit:   if (hs && cnt_q == 5'd0) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Invariant in StEmit: kr_q is the key state after forward update cnt_q.
   always_comb begin
      kr_d   = kr_q;
      cnt_d  = cnt_q;
      done_d = 1'b0;
      case (state_q)
         StIdle: begin
            if (load) begin
               kr_d  = key_in;
               cnt_d = 5'd1;
            end
         end
         StExpand: begin
            kr_d  = fwd_step(kr_q, cnt_q);
            cnt_d = (cnt_q == 5'd31) ? 5'd31 : cnt_q + 5'd1;
         end
         StEmit: begin
            if (hs) begin
               if (cnt_q != 5'd0) begin
                  kr_d  = inv_step(kr_q, cnt_q);
                  cnt_d = cnt_q - 5'd1;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         kr_q   <= '0;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         kr_q   <= kr_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   always_comb begin
      busy     = (state_q != StIdle);
      rk_valid = (state_q == StEmit);
      rk_out   = kr_q[79:16];
      rk_idx   = cnt_q;
      done     = done_q;
   end

endmodule

// File: tb/tb_present_dec_key_sched.sv
// Bench for present_dec_key_sched: known vectors, a forward-only PRESENT-80 schedule model,
// backpressure, ignored loads, back-to-back walks and reset mid-walk.
module tb_present_dec_key_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [79:0] key_in;
   logic        load;
   logic        busy;
   logic [63:0] rk_out;
   logic [4:0]  rk_idx;
   logic        rk_valid;
   logic        rk_ready;
   logic        done;

   int tests = 0;
   int fails = 0;

   logic [63:0] exp_rk [32];
   logic [63:0] got_rk [32];
   logic [3:0]  sbox_t [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

   typedef struct {
      logic [79:0] key;
      logic [4:0]  idx;
      logic [63:0] rk;
   } vec_t;

   present_dec_key_sched dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .key_in   (key_in),
      .load     (load),
      .busy     (busy),
      .rk_out   (rk_out),
      .rk_idx   (rk_idx),
      .rk_valid (rk_valid),
      .rk_ready (rk_ready),
      .done     (done)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Forward-only software schedule: round key K(i+1) is bits 79..16 after i updates.
   task automatic compute_model(input logic [79:0] key);
      logic [79:0] x, r;
      x = key;
      exp_rk[0] = x[79:16];
      for (int i = 1; i < 32; i++) begin
         for (int j = 0; j < 80; j++) r[(j + 61) % 80] = x[j];
         r[79:76] = sbox_t[r[79:76]];
         r[19:15] = r[19:15] ^ i[4:0];
         x = r;
         exp_rk[i] = x[79:16];
      end
   endtask

   // Called with load already driven high at a negedge; returns at a negedge.
   task automatic walk(input logic [79:0] key, input bit bp, input bit inject,
                       input bit chain, input logic [79:0] nkey);
      int k, hs, guard;
      bit holding;
      logic [63:0] hold_out;
      logic [4:0]  hold_idx;
      compute_model(key);
      @(posedge clk);
      @(negedge clk);
      load     = 1'b0;
      rk_ready = 1'b0;
      check("busy_after_load", 80'(busy), 80'(1));
      k = 0;
      while (!rk_valid && k < 40) begin
         load = (inject && k == 10);
         if (inject) key_in = ~key;
         @(negedge clk);
         k++;
      end
      load = 1'b0;
      check("first_valid_latency", 80'(k), 80'(31));
      if (!rk_valid) return;
      hs = 0; guard = 0; holding = 1'b0;
      hold_out = '0; hold_idx = '0;
      while (hs < 32 && guard < 400) begin
         check("valid_in_emit", 80'(rk_valid), 80'(1));
         if (!rk_valid) break;
         if (holding) begin
            check("hold_out", 80'(rk_out), 80'(hold_out));
            check("hold_idx", 80'(rk_idx), 80'(hold_idx));
         end
         rk_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         load     = (inject && hs == 5);
         if (rk_ready) begin
            check("rk_idx_seq", 80'(rk_idx), 80'(31 - hs));
            check("rk_out_model", 80'(rk_out), 80'(exp_rk[31 - hs]));
            got_rk[31 - hs] = rk_out;
            hs++;
            holding = 1'b0;
         end else begin
            holding  = 1'b1;
            hold_out = rk_out;
            hold_idx = rk_idx;
         end
         @(negedge clk);
         guard++;
      end
      rk_ready = 1'b0;
      load     = 1'b0;
      check("handshake_count", 80'(hs), 80'(32));
      check("done_pulse", 80'(done), 80'(1));
      check("valid_low_on_done", 80'(rk_valid), 80'(0));
      check("busy_low_on_done", 80'(busy), 80'(0));
      if (chain) begin
         load   = 1'b1;
         key_in = nkey;
      end else begin
         @(negedge clk);
         check("done_single_cycle", 80'(done), 80'(0));
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"},     80'(busy),     80'(0));
      check({tag, "_rk_valid"}, 80'(rk_valid), 80'(0));
      check({tag, "_rk_idx"},   80'(rk_idx),   80'(0));
      check({tag, "_rk_out"},   80'(rk_out),   80'(0));
      check({tag, "_done"},     80'(done),     80'(0));
   endtask

   initial begin
      vec_t        vecs [5];
      logic [79:0] ka, kb;
      int          w;

      vecs[0] = '{key: 80'h0, idx: 5'd1, rk: 64'hC000000000000000};
      vecs[1] = '{key: 80'h0, idx: 5'd0, rk: 64'h0000000000000000};
      vecs[2] = '{key: {80{1'b1}}, idx: 5'd0, rk: 64'hFFFFFFFFFFFFFFFF};
      vecs[3] = '{key: {80{1'b1}}, idx: 5'd1, rk: 64'h2FFFFFFFFFFFFFFF};
      vecs[4] = '{key: 80'h0123456789ABCDEF0123, idx: 5'd0, rk: 64'h0123456789ABCDEF};

      rst_n    = 1'b0;
      load     = 1'b0;
      rk_ready = 1'b0;
      key_in   = '0;
      #12;
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int v = 0; v < 5; v++) begin
         load   = 1'b1;
         key_in = vecs[v].key;
         walk(vecs[v].key, 1'b0, 1'b0, 1'b0, '0);
         check("table_vector", 80'(got_rk[vecs[v].idx]), 80'(vecs[v].rk));
      end

      for (int r = 0; r < 5; r++) begin
         ka     = {$urandom(), $urandom(), 16'($urandom())};
         load   = 1'b1;
         key_in = ka;
         walk(ka, 1'b1, 1'b0, 1'b0, '0);
      end

      // Loads during EXPAND and EMIT must be ignored.
      ka     = {$urandom(), $urandom(), 16'($urandom())};
      load   = 1'b1;
      key_in = ka;
      walk(ka, 1'b1, 1'b1, 1'b0, '0);

      // Second load lands on the done cycle.
      ka     = {$urandom(), $urandom(), 16'($urandom())};
      kb     = {$urandom(), $urandom(), 16'($urandom())};
      load   = 1'b1;
      key_in = ka;
      walk(ka, 1'b0, 1'b0, 1'b1, kb);
      walk(kb, 1'b0, 1'b0, 1'b0, '0);

      // Reset while K18 is on the bus.
      ka     = {$urandom(), $urandom(), 16'($urandom())};
      load   = 1'b1;
      key_in = ka;
      @(posedge clk);
      @(negedge clk);
      load     = 1'b0;
      rk_ready = 1'b1;
      w = 0;
      while (!(rk_valid && rk_idx == 5'd17) && w < 100) begin
         @(negedge clk);
         w++;
      end
      check("reached_idx17", 80'(rk_idx), 80'(17));
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      rk_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      kb     = {$urandom(), $urandom(), 16'($urandom())};
      load   = 1'b1;
      key_in = kb;
      walk(kb, 1'b0, 1'b0, 1'b0, '0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
